// File: rtl/bit_stuff_tx.sv
// Serial MSB-first transmitter that inserts a complement bit after RUN_MAX equal bits.
// Optional 1,0,1,0 frame preamble is enabled by defining BIT_STUFF_PREAMBLE_EN.
module bit_stuff_tx #(
    parameter int WIDTH   = 8,
    parameter int RUN_MAX = 3
) (
    input  logic             clk,
    input  logic             nRESET,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             stuffed,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(RUN_MAX + 1);

    // state_q names the kind of bit currently on out (S_IDLE when nothing is sent).
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_STUFF = 2'd2
`ifdef BIT_STUFF_PREAMBLE_EN
        , S_PRE = 2'd3
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    run_q, run_d;
    logic             last_q, last_d;
    logic             ready_q, ready_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             stf_q, stf_d;
    logic             done_q, done_d;
`ifdef BIT_STUFF_PREAMBLE_EN
    logic [2:0]       pre_q, pre_d;
`endif

    logic             emit_data;
    logic [WIDTH-1:0] sh_src;
    logic [CW-1:0]    cnt_src;
    logic [RW-1:0]    run_src;
    logic             last_src;
    logic             bit_v;
    logic [RW-1:0]    run_v;
    logic [CW-1:0]    cnt_v;

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        last_d    = last_q;
        out_d     = 1'b0;
        valid_d   = 1'b0;
        stf_d     = 1'b0;
        done_d    = 1'b0;
        emit_data = 1'b0;
        sh_src    = sh_q;
        cnt_src   = cnt_q;
        run_src   = run_q;
        last_src  = last_q;
        bit_v     = 1'b0;
        run_v     = '0;
        cnt_v     = '0;
`ifdef BIT_STUFF_PREAMBLE_EN
        pre_d     = pre_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    sh_d     = data_in;
                    cnt_d    = '0;
                    run_d    = '0;
                    last_d   = 1'b0;
                    sh_src   = data_in;
                    cnt_src  = '0;
                    run_src  = '0;
                    last_src = 1'b0;
`ifdef BIT_STUFF_PREAMBLE_EN
                    state_d  = S_PRE;
                    out_d    = 1'b1;
                    valid_d  = 1'b1;
                    pre_d    = 3'd1;
`else
                    emit_data = 1'b1;
`endif
                end
            end
`ifdef BIT_STUFF_PREAMBLE_EN
            S_PRE: begin
                if (pre_q == 3'd4) begin
                    emit_data = 1'b1;
                end else begin
                    out_d   = ~pre_q[0];
                    valid_d = 1'b1;
                    pre_d   = pre_q + 3'd1;
                end
            end
`endif
            S_DATA: begin
                if (run_q == RW'(RUN_MAX)) begin
                    out_d   = ~last_q;
                    valid_d = 1'b1;
                    stf_d   = 1'b1;
                    last_d  = ~last_q;
                    run_d   = RW'(1);
                    done_d  = (cnt_q == CW'(WIDTH));
                    state_d = S_STUFF;
                end else if (cnt_q == CW'(WIDTH)) begin
                    state_d = S_IDLE;
                end else begin
                    emit_data = 1'b1;
                end
            end
            S_STUFF: begin
                if (cnt_q == CW'(WIDTH)) state_d = S_IDLE;
                else                     emit_data = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A run of RUN_MAX on the last data bit still owes a trailing stuff bit, so no done yet.
        if (emit_data) begin
            bit_v   = sh_src[WIDTH-1];
            run_v   = (run_src != '0 && bit_v == last_src) ? run_src + RW'(1) : RW'(1);
            cnt_v   = cnt_src + CW'(1);
            sh_d    = sh_src << 1;
            cnt_d   = cnt_v;
            last_d  = bit_v;
            run_d   = run_v;
            out_d   = bit_v;
            valid_d = 1'b1;
            state_d = S_DATA;
            done_d  = (cnt_v == CW'(WIDTH)) && (run_v != RW'(RUN_MAX));
        end
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            run_q   <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            stf_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef BIT_STUFF_PREAMBLE_EN
            pre_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            stf_q   <= stf_d;
            done_q  <= done_d;
`ifdef BIT_STUFF_PREAMBLE_EN
            pre_q   <= pre_d;
`endif
        end
    end

    assign ready     = ready_q;
    assign out       = out_q;
    assign out_valid = valid_q;
    assign stuffed   = stf_q;
    assign done      = done_q;
endmodule

// File: tb/tb_bit_stuff_tx.sv
// Bench for bit_stuff_tx: frame model built from the stuffing rule, per-cycle output compare.
module tb_bit_stuff_tx;
  localparam int W = 8;
  localparam int R = 3;

  logic clk = 1'b0;
  logic nRESET = 1'b0;
  logic load = 1'b0;
  logic [W-1:0] data_in = '0;
  logic ready, out, out_valid, stuffed, done;

  int checks = 0;
  int errors = 0;

  // Expected {ready, out_valid, out, stuffed, done} per cycle; empty queue means idle.
  logic [4:0] exp_q[$];
  logic fb_q[$];
  logic fs_q[$];

  bit_stuff_tx #(.WIDTH(W), .RUN_MAX(R)) dut (
    .clk(clk), .nRESET(nRESET), .load(load), .data_in(data_in),
    .ready(ready), .out(out), .out_valid(out_valid), .stuffed(stuffed), .done(done)
  );

  always #5 clk = ~clk;

  // Frame body: data bits MSB-first, with a complement bit after every run of R.
  function automatic void build_frame(input logic [W-1:0] w);
    int run;
    logic last;
    logic b;
    fb_q.delete();
    fs_q.delete();
    run = 0;
    last = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      b = w[i];
      if (run > 0 && b == last) run++;
      else run = 1;
      last = b;
      fb_q.push_back(b);
      fs_q.push_back(1'b0);
      if (run == R) begin
        fb_q.push_back(~b);
        fs_q.push_back(1'b1);
        last = ~b;
        run = 1;
      end
    end
  endfunction

  function automatic void pin(input string name, input logic [W-1:0] w, input int exp_len,
                              input logic [15:0] exp_b, input logic [15:0] exp_s);
    logic [15:0] ab;
    logic [15:0] as;
    ab = '0;
    as = '0;
    build_frame(w);
    foreach (fb_q[i]) begin
      ab = {ab[14:0], fb_q[i]};
      as = {as[14:0], fs_q[i]};
    end
    checks++;
    if (fb_q.size() != exp_len || ab !== exp_b || as !== exp_s) begin
      errors++;
      $display("FAIL model_%s len=%0d bits=%b stuffed=%b required len=%0d bits=%b stuffed=%b",
               name, fb_q.size(), ab, as, exp_len, exp_b, exp_s);
    end
  endfunction

  function automatic void push_frame(input logic [W-1:0] w);
    build_frame(w);
`ifdef BIT_STUFF_PREAMBLE_EN
    exp_q.push_back(5'b01100);
    exp_q.push_back(5'b01000);
    exp_q.push_back(5'b01100);
    exp_q.push_back(5'b01000);
`endif
    foreach (fb_q[i])
      exp_q.push_back({1'b0, 1'b1, fb_q[i], fs_q[i], (i == fb_q.size() - 1)});
    exp_q.push_back(5'b10000);
  endfunction

  // Compare process: one check per cycle, 1 time unit after the active edge.
  initial begin
    logic [4:0] e;
    logic [4:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 5'b10000;
      act = {ready, out_valid, out, stuffed, done};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cycle t=%0t {ready,valid,out,stuffed,done} got=%b want=%b", $time, act, e);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send(input logic [W-1:0] w, input int ign, input logic [W-1:0] ign_data);
    wait_idle();
    load = 1'b1;
    data_in = w;
    push_frame(w);
    @(negedge clk);
    load = 1'b0;
    data_in = W'($urandom);
    if (ign > 0) begin
      repeat (ign - 1) @(negedge clk);
      load = 1'b1;
      data_in = ign_data;
      @(negedge clk);
      load = 1'b0;
    end
  endtask

  task automatic send_abort(input logic [W-1:0] w);
    wait_idle();
    load = 1'b1;
    data_in = w;
    push_frame(w);
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    nRESET = 1'b0;
    exp_q.delete();
    @(negedge clk);
    nRESET = 1'b1;
  endtask

  initial begin
    nRESET = 1'b0;
    repeat (2) @(negedge clk);
    nRESET = 1'b1;

    pin("a5", 8'hA5, 8,  16'b1010_0101,    16'b0);
    pin("ff", 8'hFF, 10, 16'b11_1011_1011, 16'b00_0100_0100);
    pin("e3", 8'hE3, 10, 16'b11_1000_1011, 16'b00_0100_1000);
    pin("00", 8'h00, 10, 16'b00_0100_0100, 16'b00_0100_0100);
    pin("f8", 8'hF8, 10, 16'b11_1011_0001, 16'b00_0100_0001);

    send(8'hA5, 0, 8'h00);
    send(8'hFF, 0, 8'h00);
    send(8'hE3, 3, 8'h00);
    send(8'h00, 0, 8'h00);
    send(8'hF8, 0, 8'h00);
    send_abort(8'hFF);
    send(8'hA5, 0, 8'h00);

    for (int i = 0; i < 40; i++) begin
      send(W'($urandom), $urandom_range(0, 5), W'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
